mem_responder: RTL



---
 rtl/mem_responder_pkg.sv | 20 ++
 rtl/mem_responder_io.sv | 84 ++++++++
 rtl/mem_responder.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/mem_responder_pkg.sv
// mem_responder_pkg: shared definitions for the memory responder.
//   state_t      FSM encoding (IDLE, RD_WAIT, WR_DONE)
//   IO_REGION    address[15:12] nibble that selects the IO bank
//   *_ADDR       offsets (address[11:0]) of the IO registers
package mem_responder_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_DONE = 2'd2
  } state_t;

  localparam logic [3:0]  IO_REGION   = 4'hF;

  localparam logic [11:0] LED_ADDR    = 12'h000;
  localparam logic [11:0] SW_ADDR     = 12'h001;
  localparam logic [11:0] TICK_ADDR   = 12'h002;
  localparam logic [11:0] STATUS_ADDR = 12'h003;

endpackage

// File: rtl/mem_responder_io.sv
// mem_responder_io: memory-mapped IO bank of the responder.
//   LED register (F000, r/w), two-flop switch synchronizer (F001, ro),
//   free-running tick counter (F002, ro) and status/sticky error flags
//   (F003, ro; any write clears all flags, clear beats a same-cycle set).
// Ports:
//   clk, reset            clock, synchronous active-low reset
//   io_addr               address offset within the IO region
//   io_we                 write strobe for an accepted IO store
//   led_wdata             low LED_BITS of the store data
//   sw_in                 asynchronous switch inputs
//   set_collision/overrun/protect  one-cycle sticky-flag set requests
//   io_rdata              combinational read value for io_addr
//   led_out               LED register
//   err_collision/overrun sticky flags
module mem_responder_io
  import mem_responder_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int LED_BITS = 10,
  parameter int SW_BITS  = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [11:0]         io_addr,
  input  logic                io_we,
  input  logic [LED_BITS-1:0] led_wdata,
  input  logic [SW_BITS-1:0]  sw_in,
  input  logic                set_collision,
  input  logic                set_overrun,
  input  logic                set_protect,
  output logic [WIDTH-1:0]    io_rdata,
  output logic [LED_BITS-1:0] led_out,
  output logic                err_collision,
  output logic                err_overrun
);

  logic [SW_BITS-1:0] sw_p1;
  logic [SW_BITS-1:0] sw_p2;
  logic [WIDTH-1:0]   tick;
  logic               err_protect;
  logic               status_clr;

  assign status_clr = io_we && (io_addr == STATUS_ADDR);

  always_ff @(posedge clk) begin
    if (!reset) begin
      led_out       <= '0;
      sw_p1         <= '0;
      sw_p2         <= '0;
      tick          <= '0;
      err_collision <= 1'b0;
      err_overrun   <= 1'b0;
      err_protect   <= 1'b0;
    end else begin
      sw_p1 <= sw_in;
      sw_p2 <= sw_p1;
      tick  <= tick + 1'b1;
      if (io_we && (io_addr == LED_ADDR))
        led_out <= led_wdata;
      // Clearing wins over any set arriving in the same cycle.
      if (status_clr) begin
        err_collision <= 1'b0;
        err_overrun   <= 1'b0;
        err_protect   <= 1'b0;
      end else begin
        if (set_collision) err_collision <= 1'b1;
        if (set_overrun)   err_overrun   <= 1'b1;
        if (set_protect)   err_protect   <= 1'b1;
      end
    end
  end

  always_comb begin
    io_rdata = '0;
    case (io_addr)
      LED_ADDR:    io_rdata[LED_BITS-1:0] = led_out;
      SW_ADDR:     io_rdata[SW_BITS-1:0]  = sw_p2;
      TICK_ADDR:   io_rdata               = tick;
      STATUS_ADDR: io_rdata[2:0]          = {err_protect, err_overrun, err_collision};
      default:     io_rdata               = '0;
    endcase
  end

endmodule

// File: rtl/mem_responder.sv
// mem_responder: memory-side responder for the multicycle controller's
// load/store interface. Decodes each request to the external synchronous
// block RAM or to the IO bank (mem_responder_io), returns load data one
// cycle after the request, and records protocol violations.
// Optional feature macro: MEM_RESPONDER_PROTECT_EN -- when defined, RAM
// stores below PROTECT_LIMIT are dropped and flag err_protect (status bit 2).
// Ports:
//   clk, reset                         clock, synchronous active-low reset
//   loading                            load request strobe
//   storing, write_to_memory           store request (both required)
//   addr, wr_data                      request address / store data
//   rd_data, rd_valid                  load result (valid in RD_WAIT only)
//   busy                               responder not accepting requests
//   err_collision, err_overrun         sticky protocol-violation flags
//   ram_addr, ram_we, ram_wdata        block RAM write/address side
//   ram_rdata                          block RAM read data (1-cycle latency)
//   sw_in                              asynchronous switch inputs
//   led_out                            LED register
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int               WIDTH         = 16,
  parameter int               ADDR_BITS     = 12,
  parameter int               LED_BITS      = 10,
  parameter int               SW_BITS       = 10,
  parameter logic [WIDTH-1:0] PROTECT_LIMIT = 16'h0100
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 loading,
  input  logic                 storing,
  input  logic                 write_to_memory,
  input  logic [WIDTH-1:0]     addr,
  input  logic [WIDTH-1:0]     wr_data,
  output logic [WIDTH-1:0]     rd_data,
  output logic                 rd_valid,
  output logic                 busy,
  output logic                 err_collision,
  output logic                 err_overrun,
  output logic [ADDR_BITS-1:0] ram_addr,
  output logic                 ram_we,
  output logic [WIDTH-1:0]     ram_wdata,
  input  logic [WIDTH-1:0]     ram_rdata,
  input  logic [SW_BITS-1:0]   sw_in,
  output logic [LED_BITS-1:0]  led_out
);

  state_t           state;
  state_t           state_nxt;
  logic             store_req;
  logic             io_hit;
  logic             prot_hit;
  logic             do_load;
  logic             do_store;
  logic             set_collision;
  logic             set_overrun;
  logic             set_protect;
  logic             io_we;
  logic [WIDTH-1:0] io_rdata;
  logic             io_sel_p1;
  logic [WIDTH-1:0] io_hold_p1;
  logic [WIDTH-1:0] rd_hold;
  logic [WIDTH-1:0] rd_now;

  assign store_req = storing & write_to_memory;
  assign io_hit    = (addr[WIDTH-1 -: 4] == IO_REGION);

`ifdef MEM_RESPONDER_PROTECT_EN
  assign prot_hit = !io_hit && (addr < PROTECT_LIMIT);
`else
  logic unused_protect_limit;
  assign unused_protect_limit = ^PROTECT_LIMIT;
  assign prot_hit = 1'b0;
`endif

  assign ram_addr    = addr[ADDR_BITS-1:0];
  assign ram_wdata   = wr_data;
  // No RAM write may slip out while reset is held.
  assign ram_we      = reset & do_store & !io_hit & !prot_hit;
  assign io_we       = do_store & io_hit;
  assign set_protect = do_store & prot_hit;

  always_comb begin
    state_nxt     = state;
    do_load       = 1'b0;
    do_store      = 1'b0;
    set_collision = 1'b0;
    set_overrun   = 1'b0;
    rd_valid      = 1'b0;
    busy          = 1'b0;
    case (state)
      IDLE: begin
        if (loading && store_req) begin
          set_collision = 1'b1;
        end else if (loading) begin
          do_load   = 1'b1;
          state_nxt = RD_WAIT;
        end else if (store_req) begin
          do_store  = 1'b1;
          state_nxt = WR_DONE;
        end
      end
      RD_WAIT: begin
        rd_valid    = 1'b1;
        busy        = 1'b1;
        set_overrun = loading | store_req;
        state_nxt   = IDLE;
      end
      WR_DONE: begin
        busy        = 1'b1;
        set_overrun = loading | store_req;
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request stage (p0) -> response stage (p1)
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      io_sel_p1  <= 1'b0;
      io_hold_p1 <= '0;
      rd_hold    <= '0;
    end else begin
      state <= state_nxt;
      // IO reads are captured at request time so they line up with the
      // RAM's one-cycle read latency.
      if (do_load) begin
        io_sel_p1  <= io_hit;
        io_hold_p1 <= io_rdata;
      end
      if (rd_valid)
        rd_hold <= rd_now;
    end
  end

  assign rd_now  = io_sel_p1 ? io_hold_p1 : ram_rdata;
  assign rd_data = rd_valid ? rd_now : rd_hold;

  mem_responder_io #(
    .WIDTH    (WIDTH),
    .LED_BITS (LED_BITS),
    .SW_BITS  (SW_BITS)
  ) u_io (
    .clk           (clk),
    .reset         (reset),
    .io_addr       (addr[WIDTH-5:0]),
    .io_we         (io_we),
    .led_wdata     (wr_data[LED_BITS-1:0]),
    .sw_in         (sw_in),
    .set_collision (set_collision),
    .set_overrun   (set_overrun),
    .set_protect   (set_protect),
    .io_rdata      (io_rdata),
    .led_out       (led_out),
    .err_collision (err_collision),
    .err_overrun   (err_overrun)
  );

endmodule
